// File: rtl/cmp4_sort_engine.sv
// cmp4_sort_engine: burst bubble sorter sharing one 4-bit comparator, valid/ready in and out

// comparator4bit: unsigned magnitude compare, gt is high when a > b
module comparator4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt
);
    assign gt = a > b;
endmodule

module cmp4_sort_engine #(
    parameter int N      = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        swap_count
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_P = IW'(N - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [IW-1:0]     j_q, j_d;
    logic [IW-1:0]     p_q, p_d;
    logic              swapped_q, swapped_d;
    logic [7:0]        swap_count_q, swap_count_d;
    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mem_d [N];
    logic [IW-1:0]     j1;
    logic              gt;

    assign j1 = j_q + 1'b1;

    comparator4bit u_cmp (
        .a  (mem_q[j_q]),
        .b  (mem_q[j1]),
        .gt (gt)
    );

    // next-state: capture in LOAD, one compare/swap per cycle in SORT, stream in DRAIN
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        j_d          = j_q;
        p_d          = p_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        mem_d        = mem_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d     = '0;
                        state_d      = SORT;
                        j_d          = '0;
                        p_d          = '0;
                        swapped_d    = 1'b0;
                        swap_count_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            SORT: begin
                if (gt) begin
                    mem_d[j_q]   = mem_q[j1];
                    mem_d[j1]    = mem_q[j_q];
                    swap_count_d = swap_count_q + 8'd1;
                end
                if (j_q == LAST_P - p_q) begin
                    if (!(swapped_q || gt) || p_q == LAST_P) begin
                        state_d = DRAIN;
                    end else begin
                        p_d       = p_q + 1'b1;
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j1;
                    swapped_d = swapped_q | gt;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // state and storage registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            j_q          <= '0;
            p_q          <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            j_q          <= j_d;
            p_q          <= p_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
            mem_q        <= mem_d;
        end
    end

    assign in_ready   = state_q == LOAD;
    assign out_valid  = state_q == DRAIN;
    assign out_data   = mem_q[rd_idx_q];
    assign out_last   = out_valid && rd_idx_q == LAST_IDX;
    assign busy       = state_q != LOAD;
    assign swap_count = swap_count_q;
endmodule

// File: tb/tb_cmp4_sort_engine.sv
// tb_cmp4_sort_engine: directed bursts checked against an inversion-count model of bubble sort
module tb_cmp4_sort_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] swap_count;

    int         cmp_n = 0;
    int         err_n = 0;
    int         sort_cyc = 0;
    logic [3:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data = '0;

    cmp4_sort_engine #(.N(8), .DATA_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // bubble sort performs exactly one swap per inversion
    function automatic int model_swaps(input logic [3:0] v[8]);
        int s = 0;
        for (int i = 0; i < 8; i++)
            for (int k = i + 1; k < 8; k++)
                if (v[i] > v[k]) s++;
        return s;
    endfunction

    // each pass moves an element left by one while a larger one precedes it;
    // one extra swap-free pass confirms order, capped at N-1 passes
    function automatic int model_cycles(input logic [3:0] v[8]);
        int k = 0, passes, c = 0;
        for (int i = 0; i < 8; i++) begin
            int d = 0;
            for (int m = 0; m < i; m++)
                if (v[m] > v[i]) d++;
            if (d > k) k = d;
        end
        passes = (k + 1 < 7) ? k + 1 : 7;
        for (int p = 0; p < passes; p++) c += 7 - p;
        return c;
    endfunction

    function automatic void model_sort(input logic [3:0] v[8], output logic [3:0] s[8]);
        s = v;
        for (int i = 1; i < 8; i++) begin
            logic [3:0] t = s[i];
            int m = i - 1;
            while (m >= 0 && s[m] > t) begin
                s[m + 1] = s[m];
                m--;
            end
            s[m + 1] = t;
        end
    endfunction

    // output-side checker: every visible word must match the model's head of line
    always @(negedge clk) begin
        if (rst_n && busy && !out_valid) sort_cyc++;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, exp_q.size() == 1);
                chk("busy_in_drain", busy, 1);
                chk("in_ready_in_drain", in_ready, 0);
                if (prev_stall) chk("out_data_stable", out_data, prev_data);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_data  = out_data;
    end

    task automatic load_burst(input logic [3:0] v[8]);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            @(posedge clk); #1;
        end
        in_data = 4'hA;
        @(negedge clk);
        chk("in_ready_after_load", in_ready, 0);
        chk("busy_sort_entry", busy, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_burst(input logic [3:0] v[8], input logic [3:0] lit[8],
                             input int lit_sw, input int lit_cyc, input int stall);
        logic [3:0] s[8];
        int cnt = 0;
        model_sort(v, s);
        for (int i = 0; i < 8; i++) chk("model_sorted_pin", s[i], lit[i]);
        chk("model_swaps_pin", model_swaps(v), lit_sw);
        chk("model_cycles_pin", model_cycles(v), lit_cyc);
        sort_cyc = 0;
        load_burst(v);
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
        while (exp_q.size() > 0 && cnt < 600) begin
            out_ready = stall ? (cnt % 4 == 3) : 1'b1;
            in_valid  = exp_q.size() > 1 ? 1'($urandom % 2) : 1'b0;
            in_data   = 4'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_after_drain", in_ready, 1);
        chk("out_valid_after_drain", out_valid, 0);
        chk("busy_after_drain", busy, 0);
        chk("swap_count", swap_count, model_swaps(v));
        chk("sort_cycles", sort_cyc, model_cycles(v));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] rev[8] = '{15, 14, 13, 12, 11, 10, 9, 8};
        int n = 0;
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_swap_count", swap_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst('{7, 3, 9, 0, 15, 3, 1, 8}, '{0, 1, 3, 3, 7, 8, 9, 15}, 14, 27, 0);
        run_burst('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 1, 2, 3, 4, 5, 6, 7}, 0, 7, 0);
        run_burst(rev, '{8, 9, 10, 11, 12, 13, 14, 15}, 28, 28, 0);
        run_burst('{5, 5, 5, 5, 5, 5, 5, 5}, '{5, 5, 5, 5, 5, 5, 5, 5}, 0, 7, 0);
        run_burst('{7, 3, 9, 0, 15, 3, 1, 8}, '{0, 1, 3, 3, 7, 8, 9, 15}, 14, 27, 1);

        sort_cyc = 0;
        load_burst(rev);
        in_valid = 1'b0;
        while (sort_cyc < 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_sort", busy && !out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_swap_count", swap_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_burst('{2, 1, 4, 3, 6, 5, 0, 7}, '{0, 1, 2, 3, 4, 5, 6, 7}, 9, 28, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
